// File: rtl/hazard_unit_if.sv
// Datapath <-> hazard unit bundle: D-stage instruction and flush in, stall/bypass selects and md_busy out.
interface hazard_unit_if;
   logic [31:0] instr_d;
   logic        flush;
   logic        stall;
   logic [1:0]  fwd_rs_d;
   logic [1:0]  fwd_rt_d;
   logic [1:0]  fwd_rs_e;
   logic [1:0]  fwd_rt_e;
   logic        fwd_rt_m;
   logic        md_busy;

   modport master (
      output instr_d, flush,
      input  stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m, md_busy
   );

   modport slave (
      input  instr_d, flush,
      output stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m, md_busy
   );
endinterface

// File: rtl/hazard_unit.sv
// Stall/forward controller for the 5-stage MIPS pipeline: Tuse/Tnew decode of D, a shadow
// E/M/W destination pipeline and a HI/LO busy counter.
module hazard_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10,
   parameter bit FWD_EN      = 1'b1
) (
   input  logic         clk,
   input  logic         reset,
   hazard_unit_if.slave hif
);

   localparam int MD_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W  = $clog2(MD_MAX + 1);
   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

   function automatic logic [1:0] sat_dec(input logic [1:0] t);
      return (t == 2'd0) ? 2'd0 : t - 2'd1;
   endfunction

   function automatic logic [1:0] pick_d(input logic [4:0] src,
                                         input logic [4:0] ed, input logic [1:0] et,
                                         input logic [4:0] md, input logic [1:0] mt,
                                         input logic [4:0] wd, input logic [1:0] wt);
      if (src == 5'd0)                 return 2'b00;
      if (ed == src && et == 2'd0)     return 2'b01;
      if (md == src && mt == 2'd0)     return 2'b10;
      if (wd == src && wt == 2'd0)     return 2'b11;
      return 2'b00;
   endfunction

   logic [5:0] op, funct;
   logic [4:0] rs_f, rt_f, rd_f;
   logic r_type, is_jr, is_jalr, is_regimm, is_beq_bne, is_blez_bgtz, is_br;
   logic is_ialu, is_alu_r, is_alu, is_ld, is_st, is_jal;
   logic is_mfc0, is_mtc0, is_eret, is_mult, is_div, is_md, is_mtc0_epc;
   logic rs_used, rt_used;
   logic [4:0] src_rs, src_rt, dst_dec;
   logic [1:0] tuse_rs, tuse_rt, tnew_dec;

   assign op     = hif.instr_d[31:26];
   assign rs_f   = hif.instr_d[25:21];
   assign rt_f   = hif.instr_d[20:16];
   assign rd_f   = hif.instr_d[15:11];
   assign funct  = hif.instr_d[5:0];

   assign r_type       = (op == 6'h00);
   assign is_jr        = r_type && (funct == 6'h08);
   assign is_jalr      = r_type && (funct == 6'h09);
   assign is_regimm    = (op == 6'h01);
   assign is_beq_bne   = (op == 6'h04) || (op == 6'h05);
   assign is_blez_bgtz = (op == 6'h06) || (op == 6'h07);
   assign is_br        = is_jr || is_jalr || is_regimm || is_beq_bne || is_blez_bgtz;
   assign is_ialu      = (op[5:3] == 3'b001);
   assign is_alu_r     = r_type && !is_jr && !is_jalr;
   assign is_alu       = is_alu_r || is_ialu;
   assign is_ld        = (op == 6'h20) || (op == 6'h21) || (op == 6'h23) || (op == 6'h24) || (op == 6'h25);
   assign is_st        = (op == 6'h28) || (op == 6'h29) || (op == 6'h2B);
   assign is_jal       = (op == 6'h03);
   assign is_mfc0      = (op == 6'h10) && (rs_f == 5'd0);
   assign is_mtc0      = (op == 6'h10) && (rs_f == 5'd4);
   assign is_eret      = (hif.instr_d == 32'h4200_0018);
   assign is_mult      = r_type && (funct == 6'h18 || funct == 6'h19);
   assign is_div       = r_type && (funct == 6'h1A || funct == 6'h1B);
   assign is_md        = r_type && (funct[5:2] == 4'b0100 || funct[5:2] == 4'b0110);
   assign is_mtc0_epc  = is_mtc0 && (rd_f == 5'd14);

   // Jump targets and cop0 selector bits overlap rs/rt, so only real source fields are kept.
   assign rs_used = r_type || is_regimm || is_beq_bne || is_blez_bgtz || is_ialu || is_ld || is_st;
   assign rt_used = r_type || is_beq_bne || is_st || is_mtc0;
   assign src_rs  = rs_used ? rs_f : 5'd0;
   assign src_rt  = rt_used ? rt_f : 5'd0;
   assign tuse_rs = is_br ? 2'd0 : 2'd1;
   assign tuse_rt = is_beq_bne ? 2'd0 : (r_type ? 2'd1 : 2'd2);

   always_comb begin
      dst_dec  = 5'd0;
      tnew_dec = 2'd0;
      if (is_alu_r || is_jalr)             dst_dec = rd_f;
      else if (is_ialu || is_ld || is_mfc0) dst_dec = rt_f;
      else if (is_jal)                     dst_dec = 5'd31;
      if (is_ld || is_mfc0)                tnew_dec = 2'd2;
      else if (is_alu)                     tnew_dec = 2'd1;
   end

   logic [4:0] e_dst_q, e_dst_d, e_rs_q, e_rs_d, e_rt_q, e_rt_d;
   logic [1:0] e_tnew_q, e_tnew_d;
   logic       e_mult_q, e_mult_d, e_div_q, e_div_d, e_epc_q, e_epc_d;
   logic [4:0] m_dst_q, m_dst_d, m_rt_q, m_rt_d;
   logic [1:0] m_tnew_q, m_tnew_d;
   logic       m_epc_q, m_epc_d;
   logic [4:0] w_dst_q, w_dst_d;
   logic [1:0] w_tnew_q, w_tnew_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic haz_rs, haz_rt, pend_rs, pend_rt, md_stall, eret_stall, stall;

   assign haz_rs = (src_rs != 5'd0) &&
                   ((src_rs == e_dst_q && e_tnew_q > tuse_rs) || (src_rs == m_dst_q && m_tnew_q > tuse_rs));
   assign haz_rt = (src_rt != 5'd0) &&
                   ((src_rt == e_dst_q && e_tnew_q > tuse_rt) || (src_rt == m_dst_q && m_tnew_q > tuse_rt));
   assign pend_rs    = (src_rs != 5'd0) && (src_rs == e_dst_q || src_rs == m_dst_q);
   assign pend_rt    = (src_rt != 5'd0) && (src_rt == e_dst_q || src_rt == m_dst_q);
   assign md_stall   = is_md && (hif.md_busy || e_mult_q || e_div_q);
   assign eret_stall = is_eret && (e_epc_q || m_epc_q);
   assign stall      = haz_rs || haz_rt || md_stall || eret_stall || (!FWD_EN && (pend_rs || pend_rt));

   assign hif.stall   = stall;
   assign hif.md_busy = (cnt_q != '0);

   always_comb begin
      hif.fwd_rs_d = 2'b00;
      hif.fwd_rt_d = 2'b00;
      hif.fwd_rs_e = 2'b00;
      hif.fwd_rt_e = 2'b00;
      hif.fwd_rt_m = 1'b0;
      if (FWD_EN) begin
         hif.fwd_rs_d = pick_d(src_rs, e_dst_q, e_tnew_q, m_dst_q, m_tnew_q, w_dst_q, w_tnew_q);
         hif.fwd_rt_d = pick_d(src_rt, e_dst_q, e_tnew_q, m_dst_q, m_tnew_q, w_dst_q, w_tnew_q);
         if (e_rs_q != 5'd0 && e_rs_q == m_dst_q && m_tnew_q == 2'd0)      hif.fwd_rs_e = 2'b01;
         else if (e_rs_q != 5'd0 && e_rs_q == w_dst_q && w_tnew_q == 2'd0) hif.fwd_rs_e = 2'b10;
         if (e_rt_q != 5'd0 && e_rt_q == m_dst_q && m_tnew_q == 2'd0)      hif.fwd_rt_e = 2'b01;
         else if (e_rt_q != 5'd0 && e_rt_q == w_dst_q && w_tnew_q == 2'd0) hif.fwd_rt_e = 2'b10;
         hif.fwd_rt_m = (m_rt_q != 5'd0) && (m_rt_q == w_dst_q) && (w_tnew_q == 2'd0);
      end
   end

   // Flush overrides stall: every shadow stage becomes a bubble, but the md counter keeps running.
   always_comb begin
      e_dst_d  = dst_dec;
      e_tnew_d = tnew_dec;
      e_rs_d   = src_rs;
      e_rt_d   = src_rt;
      e_mult_d = is_mult;
      e_div_d  = is_div;
      e_epc_d  = is_mtc0_epc;
      m_dst_d  = e_dst_q;
      m_tnew_d = sat_dec(e_tnew_q);
      m_rt_d   = e_rt_q;
      m_epc_d  = e_epc_q;
      w_dst_d  = m_dst_q;
      w_tnew_d = sat_dec(m_tnew_q);
      if (stall || hif.flush) begin
         e_dst_d  = 5'd0;
         e_tnew_d = 2'd0;
         e_rs_d   = 5'd0;
         e_rt_d   = 5'd0;
         e_mult_d = 1'b0;
         e_div_d  = 1'b0;
         e_epc_d  = 1'b0;
      end
      if (hif.flush) begin
         m_dst_d  = 5'd0;
         m_tnew_d = 2'd0;
         m_rt_d   = 5'd0;
         m_epc_d  = 1'b0;
         w_dst_d  = 5'd0;
         w_tnew_d = 2'd0;
      end
      if (e_mult_q)           cnt_d = MULT_LOAD;
      else if (e_div_q)       cnt_d = DIV_LOAD;
      else if (cnt_q != '0)   cnt_d = cnt_q - CNT_W'(1);
      else                    cnt_d = cnt_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         e_dst_q  <= '0;
         e_tnew_q <= '0;
         e_rs_q   <= '0;
         e_rt_q   <= '0;
         e_mult_q <= 1'b0;
         e_div_q  <= 1'b0;
         e_epc_q  <= 1'b0;
         m_dst_q  <= '0;
         m_tnew_q <= '0;
         m_rt_q   <= '0;
         m_epc_q  <= 1'b0;
         w_dst_q  <= '0;
         w_tnew_q <= '0;
         cnt_q    <= '0;
      end else begin
         e_dst_q  <= e_dst_d;
         e_tnew_q <= e_tnew_d;
         e_rs_q   <= e_rs_d;
         e_rt_q   <= e_rt_d;
         e_mult_q <= e_mult_d;
         e_div_q  <= e_div_d;
         e_epc_q  <= e_epc_d;
         m_dst_q  <= m_dst_d;
         m_tnew_q <= m_tnew_d;
         m_rt_q   <= m_rt_d;
         m_epc_q  <= m_epc_d;
         w_dst_q  <= w_dst_d;
         w_tnew_q <= w_tnew_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: directed instruction sequences push expected outputs,
// a negedge monitor pops and compares against either the bypassing or the non-bypassing instance.
module tb_hazard_unit;

   localparam logic [31:0] NOP       = 32'h0000_0000;
   localparam logic [31:0] LW_2      = 32'h8C02_0000;
   localparam logic [31:0] ADDU_3_22 = 32'h0042_1821;
   localparam logic [31:0] ADDU_4_11 = 32'h0021_2021;
   localparam logic [31:0] BEQ_4_0   = 32'h1080_0003;
   localparam logic [31:0] JAL       = 32'h0C00_0010;
   localparam logic [31:0] JR_31     = 32'h03E0_0008;
   localparam logic [31:0] MULT_12   = 32'h0022_0018;
   localparam logic [31:0] MFLO_3    = 32'h0000_1812;
   localparam logic [31:0] DIV_12    = 32'h0022_001A;
   localparam logic [31:0] ADDU_0_11 = 32'h0021_0021;
   localparam logic [31:0] ADDU_5_00 = 32'h0000_2821;
   localparam logic [31:0] ADDU_5_44 = 32'h0084_2821;
   localparam logic [31:0] SW_4      = 32'hAC04_0000;
   localparam logic [31:0] SW_2      = 32'hAC02_0000;
   localparam logic [31:0] MTC0_2_14 = 32'h4082_7000;
   localparam logic [31:0] MTC0_2_12 = 32'h4082_6000;
   localparam logic [31:0] ERET      = 32'h4200_0018;

   // Expected word layout: stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m, md_busy
   localparam logic [10:0] NONE  = 11'b0_00_00_00_00_0_0;
   localparam logic [10:0] STALL = 11'b1_00_00_00_00_0_0;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   hazard_unit_if hif();
   hazard_unit_if hif_nf();

   hazard_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10), .FWD_EN(1'b1)) dut (
      .clk(clk), .reset(reset), .hif(hif)
   );

   hazard_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10), .FWD_EN(1'b0)) dut_nf (
      .clk(clk), .reset(reset), .hif(hif_nf)
   );

   logic [11:0] exp_q[$];
   string       name_q[$];
   int          tests_run = 0;
   int          tests_failed = 0;

   function automatic logic [10:0] mk_exp(input bit st, input logic [1:0] rsd, input logic [1:0] rtd,
                                          input logic [1:0] rse, input logic [1:0] rte,
                                          input bit rtm, input bit busy);
      return {st, rsd, rtd, rse, rte, rtm, busy};
   endfunction

   task automatic applyStimulus(input string name, input bit sel, input bit rst,
                                input logic [31:0] instr, input bit fl, input logic [10:0] exp);
      @(posedge clk);
      #1;
      reset          = rst;
      hif.instr_d    = instr;
      hif.flush      = fl;
      hif_nf.instr_d = instr;
      hif_nf.flush   = fl;
      exp_q.push_back({sel, exp});
      name_q.push_back(name);
   endtask

   task automatic checkOutput(input string name, input logic [11:0] word);
      logic [10:0] act;
      if (word[11])
         act = {hif_nf.stall, hif_nf.fwd_rs_d, hif_nf.fwd_rt_d, hif_nf.fwd_rs_e, hif_nf.fwd_rt_e,
                hif_nf.fwd_rt_m, hif_nf.md_busy};
      else
         act = {hif.stall, hif.fwd_rs_d, hif.fwd_rt_d, hif.fwd_rs_e, hif.fwd_rt_e,
                hif.fwd_rt_m, hif.md_busy};
      tests_run++;
      if (act !== word[10:0]) begin
         tests_failed++;
         $display("[TB] FAIL %s (fwd_en=%0d): got %b_%b_%b_%b_%b_%b_%b expected %b_%b_%b_%b_%b_%b_%b",
                  name, !word[11], act[10], act[9:8], act[7:6], act[5:4], act[3:2], act[1], act[0],
                  word[10], word[9:8], word[7:6], word[5:4], word[3:2], word[1], word[0]);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         checkOutput(name_q.pop_front(), exp_q.pop_front());
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset          = 1'b1;
      hif.instr_d    = NOP;
      hif.flush      = 1'b0;
      hif_nf.instr_d = NOP;
      hif_nf.flush   = 1'b0;
      repeat (3) @(posedge clk);

      applyStimulus("reset_state",    0, 0, NOP, 0, NONE);
      applyStimulus("reset_state_nf", 1, 0, NOP, 0, NONE);

      // Load-use: one bubble, then the consumer takes both operands from W in E.
      applyStimulus("lw_issue",      0, 0, LW_2,      0, NONE);
      applyStimulus("lw_use_stall",  0, 0, ADDU_3_22, 0, STALL);
      applyStimulus("lw_use_go",     0, 0, ADDU_3_22, 0, NONE);
      applyStimulus("lw_use_fwd_e",  0, 0, NOP,       0, mk_exp(0, 2'b00, 2'b00, 2'b10, 2'b10, 0, 0));
      applyStimulus("lw_drain1",     0, 0, NOP,       0, NONE);
      applyStimulus("lw_drain2",     0, 0, NOP,       0, NONE);

      // ALU result feeding a branch: one stall, then the M bypass into D.
      applyStimulus("alu_issue",     0, 0, ADDU_4_11, 0, NONE);
      applyStimulus("br_stall",      0, 0, BEQ_4_0,   0, STALL);
      applyStimulus("br_fwd_m",      0, 0, BEQ_4_0,   0, mk_exp(0, 2'b10, 2'b00, 2'b00, 2'b00, 0, 0));
      applyStimulus("br_e_from_w",   0, 0, NOP,       0, mk_exp(0, 2'b00, 2'b00, 2'b10, 2'b00, 0, 0));
      applyStimulus("br_drain",      0, 0, NOP,       0, NONE);

      // Link value is available in E: jr takes it with no stall.
      applyStimulus("jal_issue",     0, 0, JAL,       0, NONE);
      applyStimulus("jr_fwd_link",   0, 0, JR_31,     0, mk_exp(0, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0));
      applyStimulus("jr_e_from_m",   0, 0, NOP,       0, mk_exp(0, 2'b00, 2'b00, 2'b01, 2'b00, 0, 0));
      applyStimulus("jr_drain",      0, 0, NOP,       0, NONE);

      // mult then mflo: one stall while mult sits in E, then MULT_CYCLES of busy.
      applyStimulus("mult_issue",    0, 0, MULT_12,   0, NONE);
      applyStimulus("mflo_e_mult",   0, 0, MFLO_3,    0, STALL);
      for (int i = 0; i < 5; i++)
         applyStimulus("mflo_busy",  0, 0, MFLO_3,    0, mk_exp(1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1));
      applyStimulus("mflo_go",       0, 0, MFLO_3,    0, NONE);
      applyStimulus("md_drain",      0, 0, NOP,       0, NONE);

      // Writes to $0 never create hazards or bypasses.
      applyStimulus("zero_writer",   0, 0, ADDU_0_11, 0, NONE);
      applyStimulus("zero_reader1",  0, 0, ADDU_5_00, 0, NONE);
      applyStimulus("zero_reader2",  0, 0, ADDU_5_00, 0, NONE);
      applyStimulus("zero_drain",    0, 0, NOP,       0, NONE);

      // Flush with a load in E: the pending producer disappears.
      applyStimulus("flush_lw",      0, 0, LW_2,      0, NONE);
      applyStimulus("flush_cycle",   0, 0, ADDU_3_22, 1, STALL);
      applyStimulus("flush_no_stall",0, 0, ADDU_3_22, 0, NONE);
      applyStimulus("flush_m_clear", 0, 0, NOP,       0, NONE);
      applyStimulus("flush_drain",   0, 0, NOP,       0, NONE);

      // Synchronous reset in the middle of a divide clears md_busy.
      applyStimulus("div_issue",     0, 0, DIV_12,    0, NONE);
      applyStimulus("div_in_e",      0, 0, NOP,       0, NONE);
      applyStimulus("div_busy1",     0, 0, NOP,       0, mk_exp(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1));
      applyStimulus("div_busy2",     0, 0, NOP,       0, mk_exp(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1));
      applyStimulus("div_reset",     0, 1, NOP,       0, mk_exp(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1));
      applyStimulus("div_after_rst", 0, 0, NOP,       0, NONE);

      // eret waits for an in-flight EPC write, but not for other cop0 writes.
      applyStimulus("mtc0_epc",      0, 0, MTC0_2_14, 0, NONE);
      applyStimulus("eret_e_epc",    0, 0, ERET,      0, STALL);
      applyStimulus("eret_m_epc",    0, 0, ERET,      0, STALL);
      applyStimulus("eret_go",       0, 0, ERET,      0, NONE);
      applyStimulus("mtc0_status",   0, 0, MTC0_2_12, 0, NONE);
      applyStimulus("eret_no_epc",   0, 0, ERET,      0, NONE);

      // Store data: Tuse of 2 lets it ride to E/M and pick up the value late.
      applyStimulus("st_alu_issue",  0, 0, ADDU_4_11, 0, NONE);
      applyStimulus("st_no_stall",   0, 0, SW_4,      0, NONE);
      applyStimulus("st_rt_e_m",     0, 0, NOP,       0, mk_exp(0, 2'b00, 2'b00, 2'b00, 2'b01, 0, 0));
      applyStimulus("st_rt_m_w",     0, 0, NOP,       0, mk_exp(0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0));
      applyStimulus("st_drain",      0, 0, NOP,       0, NONE);
      applyStimulus("lw_st_issue",   0, 0, LW_2,      0, NONE);
      applyStimulus("lw_st_nostall", 0, 0, SW_2,      0, NONE);
      applyStimulus("lw_st_e_wait",  0, 0, NOP,       0, NONE);
      applyStimulus("lw_st_m_fwd",   0, 0, NOP,       0, mk_exp(0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0));
      applyStimulus("lw_st_drain",   0, 0, NOP,       0, NONE);
      applyStimulus("nf_idle",       1, 0, NOP,       0, NONE);

      // Without bypassing, consumers wait until the producer reaches W.
      applyStimulus("nf_alu_issue",  1, 0, ADDU_4_11, 0, NONE);
      applyStimulus("nf_stall_e",    1, 0, ADDU_5_44, 0, STALL);
      applyStimulus("nf_stall_m",    1, 0, ADDU_5_44, 0, STALL);
      applyStimulus("nf_go_no_fwd",  1, 0, ADDU_5_44, 0, NONE);
      applyStimulus("nf_jal_issue",  1, 0, JAL,       0, NONE);
      applyStimulus("nf_jr_stall_e", 1, 0, JR_31,     0, STALL);
      applyStimulus("nf_jr_stall_m", 1, 0, JR_31,     0, STALL);
      applyStimulus("nf_jr_go",      1, 0, JR_31,     0, NONE);

      @(posedge clk);
      @(negedge clk);
      #1;
      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
